sync_tcounter: RTL and testbench



---
 rtl/sync_tcounter_pkg.sv | 28 ++
 rtl/sync_tcounter_tff_sync.sv | 41 ++++
 rtl/sync_tcounter.sv | 132 +++++++++++++
 tb/tb_sync_tcounter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sync_tcounter_pkg.sv
// sync_tcounter_pkg
//   Shared definitions for the synchronous modulus counter.
//   - act_e     : action chosen for the coming clock edge
//   - params_ok : elaboration-time legality check of WIDTH/MOD/RESET_VAL
package sync_tcounter_pkg;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 16;
  localparam int MIN_MOD   = 2;

  // Per-edge action once reset has been excluded (Load > En > hold).
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_STEP = 2'd2
  } act_e;

  // True when the parameter set describes a realisable counter.
  function automatic bit params_ok(input int width, input int modv, input int reset_val);
    bit ok;
    ok = 1'b1;
    if (width < MIN_WIDTH || width > MAX_WIDTH) ok = 1'b0;
    else if (modv < MIN_MOD || modv > (1 << width)) ok = 1'b0;
    else if (reset_val < 0 || reset_val >= modv) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sync_tcounter_tff_sync.sv
// tff_sync
//   One-bit synchronous toggle flop with a synchronous parallel-load path.
//   Priority on the rising edge: Reset_BAR low > LoadEn > T > hold.
//   Ports:
//     CLK       in   clock
//     Reset_BAR in   synchronous active-low reset, loads INIT
//     T         in   toggle request
//     LoadEn    in   parallel-load strobe
//     LoadVal   in   value taken when LoadEn is high
//     Q         out  registered bit
//     Q_BAR     out  complement of Q, derived from the same register
module tff_sync
  import sync_tcounter_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic CLK,
  input  logic Reset_BAR,
  input  logic T,
  input  logic LoadEn,
  input  logic LoadVal,
  output logic Q,
  output logic Q_BAR
);

  logic q_r;

  always_ff @(posedge CLK) begin
    if (!Reset_BAR) begin
      q_r <= INIT;
    end else if (LoadEn) begin
      q_r <= LoadVal;
    end else if (T) begin
      q_r <= ~q_r;
    end
  end

  assign Q     = q_r;
  assign Q_BAR = ~q_r;

endmodule

// File: rtl/sync_tcounter.sv
// sync_tcounter
//   Synchronous modulo-MOD up/down counter built from WIDTH toggle flops.
//   Count sequence is 0..MOD-1, wrapping in either direction.
//   Ports:
//     CLK       in   clock, all state changes on the rising edge
//     Reset_BAR in   synchronous active-low reset (Q <= RESET_VAL, flags cleared)
//     En        in   count enable
//     Up        in   1 = increment, 0 = decrement
//     Load      in   parallel-load strobe, overrides En
//     D         in   load value; values >= MOD load 0 and raise LoadErr
//     Q         out  registered count
//     Q_BAR     out  ~Q
//     TC        out  combinational terminal count, usable as En of a next stage
//     Wrap      out  one-cycle pulse after a wrapping count edge
//     LoadErr   out  one-cycle pulse after an out-of-range load
module sync_tcounter
  import sync_tcounter_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int MOD       = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             Reset_BAR,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_BAR,
  output logic             TC,
  output logic             Wrap,
  output logic             LoadErr
);

  if (!params_ok(WIDTH, MOD, RESET_VAL)) begin : g_bad_params
    $error("sync_tcounter: illegal parameters WIDTH=%0d MOD=%0d RESET_VAL=%0d",
           WIDTH, MOD, RESET_VAL);
  end

  // The modulus may equal 2^WIDTH, which does not fit in WIDTH bits; every
  // compare is therefore made against MAXV so it stays WIDTH bits wide.
  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  act_e             act;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] toggle;
  logic             at_max;
  logic             at_zero;
  logic             at_term;
  logic             load_bad;
  logic             bit_load;
  logic             wrap_r;
  logic             load_err_r;

  always_comb begin
    act = ACT_HOLD;
    if (Load)    act = ACT_LOAD;
    else if (En) act = ACT_STEP;
  end

  assign at_max   = (q == MAXV);
  assign at_zero  = (q == ZERO);
  assign at_term  = Up ? at_max : at_zero;
  assign load_bad = (D > MAXV);

  always_comb begin
    nxt = q;
    unique case (act)
      ACT_LOAD: nxt = load_bad ? ZERO : D;
      ACT_STEP: begin
        if (Up) nxt = at_max  ? ZERO : q + WIDTH'(1);
        else    nxt = at_zero ? MAXV : q - WIDTH'(1);
      end
      default:  nxt = q;
    endcase
  end

  // Ordinary steps are expressed as per-bit toggles (the generalised D = Q_BAR
  // flop). Loads and modulus wraps jump to a value that is not a binary
  // neighbour, so those go through the parallel-load path instead.
  assign bit_load = (act == ACT_LOAD) || ((act == ACT_STEP) && at_term);
  assign toggle   = ((act == ACT_STEP) && !at_term) ? (q ^ nxt) : ZERO;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_sync #(
      .INIT (RST_V[i])
    ) u_tff (
      .CLK       (CLK),
      .Reset_BAR (Reset_BAR),
      .T         (toggle[i]),
      .LoadEn    (bit_load),
      .LoadVal   (nxt[i]),
      .Q         (q[i]),
      .Q_BAR     (q_bar[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (!Reset_BAR) begin
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      unique case (act)
        ACT_LOAD: begin
          wrap_r     <= 1'b0;
          load_err_r <= load_bad;
        end
        ACT_STEP: begin
          wrap_r     <= at_term;
          load_err_r <= 1'b0;
        end
        default: begin
          wrap_r     <= 1'b0;
          load_err_r <= 1'b0;
        end
      endcase
    end
  end

  // TC deliberately ignores Load so a cascade sees a pure count-carry.
  assign TC      = En & ((Up & at_max) | (~Up & at_zero));
  assign Q       = q;
  assign Q_BAR   = q_bar;
  assign Wrap    = wrap_r;
  assign LoadErr = load_err_r;

endmodule

// File: tb/tb_sync_tcounter.sv
// tb_sync_tcounter
//   Directed bench: a WIDTH=3/MOD=6 counter plus two WIDTH=2/MOD=4 counters
//   cascaded through TC into a 16-state counter.
module tb_sync_tcounter;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  // single mod-6 instance
  logic       rst_b, en, up, load;
  logic [2:0] d, q, qb;
  logic       tc, wrap, lerr;

  // cascaded mod-4 pair
  logic       c_rst_b, c_en, c_up;
  logic       c_load;
  logic [1:0] c_d;
  logic [1:0] lo_q, lo_qb, hi_q, hi_qb;
  logic       lo_tc, lo_wrap, lo_lerr, hi_tc, hi_wrap, hi_lerr;

  int checks   = 0;
  int failures = 0;

  sync_tcounter #(.WIDTH(3), .MOD(6), .RESET_VAL(0)) u_dut (
    .CLK(CLK), .Reset_BAR(rst_b), .En(en), .Up(up), .Load(load), .D(d),
    .Q(q), .Q_BAR(qb), .TC(tc), .Wrap(wrap), .LoadErr(lerr)
  );

  sync_tcounter #(.WIDTH(2), .MOD(4), .RESET_VAL(0)) u_lo (
    .CLK(CLK), .Reset_BAR(c_rst_b), .En(c_en), .Up(c_up), .Load(c_load), .D(c_d),
    .Q(lo_q), .Q_BAR(lo_qb), .TC(lo_tc), .Wrap(lo_wrap), .LoadErr(lo_lerr)
  );

  sync_tcounter #(.WIDTH(2), .MOD(4), .RESET_VAL(0)) u_hi (
    .CLK(CLK), .Reset_BAR(c_rst_b), .En(lo_tc), .Up(c_up), .Load(c_load), .D(c_d),
    .Q(hi_q), .Q_BAR(hi_qb), .TC(hi_tc), .Wrap(hi_wrap), .LoadErr(hi_lerr)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  int         q_up [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
  int         q_dn [6] = '{3, 2, 1, 0, 5, 4};
  int         prev;
  int         val;
  logic [2:0] e3, nb3;
  logic [1:0] e2, nb2;

  initial begin
    rst_b = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = 3'd0;
    c_rst_b = 1'b0; c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_d = 2'd0;

    // reset state
    tick;
    check_val("rst_q", q, 0);
    check_val("rst_qbar", qb, 7);
    check_val("rst_wrap", wrap, 0);
    check_val("rst_lerr", lerr, 0);
    check_val("rst_tc", tc, 0);
    check_val("rst_lo_q", lo_q, 0);
    check_val("rst_hi_q", hi_q, 0);

    // count up through the modulus
    rst_b = 1'b1; c_rst_b = 1'b1; en = 1'b1; up = 1'b1;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("up_tc[%0d]", i), tc, (prev == 5) ? 1 : 0);
      tick;
      e3 = 3'(q_up[i]); nb3 = ~e3;
      check_val($sformatf("up_q[%0d]", i), q, e3);
      check_val($sformatf("up_qbar[%0d]", i), qb, nb3);
      check_val($sformatf("up_wrap[%0d]", i), wrap, (q_up[i] == 0) ? 1 : 0);
      prev = q_up[i];
    end

    // load 4, then count down through zero
    load = 1'b1; d = 3'd4; en = 1'b1; up = 1'b0;
    tick;
    check_val("ld4_q", q, 4);
    check_val("ld4_wrap", wrap, 0);
    check_val("ld4_lerr", lerr, 0);
    load = 1'b0;
    prev = 4;
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("dn_tc[%0d]", i), tc, (prev == 0) ? 1 : 0);
      tick;
      check_val($sformatf("dn_q[%0d]", i), q, q_dn[i]);
      check_val($sformatf("dn_wrap[%0d]", i), wrap, (q_dn[i] == 5) ? 1 : 0);
      prev = q_dn[i];
    end

    // out-of-range load, load priority over En, boundary load of MOD-1
    en = 1'b0; load = 1'b1; d = 3'd7;
    tick;
    check_val("ld7_q", q, 0);
    check_val("ld7_lerr", lerr, 1);
    check_val("ld7_wrap", wrap, 0);
    load = 1'b0;
    tick;
    check_val("ld7_lerr_clr", lerr, 0);
    check_val("ld7_q_hold", q, 0);
    load = 1'b1; en = 1'b1; up = 1'b1; d = 3'd2;
    tick;
    check_val("ld2_en_q", q, 2);
    check_val("ld2_en_lerr", lerr, 0);
    d = 3'd5;
    tick;
    check_val("ld5_q", q, 5);
    check_val("ld5_lerr", lerr, 0);
    load = 1'b0;
    check_val("max_tc", tc, 1);
    tick;
    check_val("max_wrap_q", q, 0);
    check_val("max_wrap", wrap, 1);
    load = 1'b1; d = 3'd1;
    tick;
    check_val("ld_clr_wrap", wrap, 0);
    check_val("ld1_q", q, 1);

    // synchronous reset mid-count, overriding Load and En
    load = 1'b1; d = 3'd3; en = 1'b0;
    tick;
    check_val("ld3_q", q, 3);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick;
    check_val("cnt4_q", q, 4);
    rst_b = 1'b0; load = 1'b1; d = 3'd5;
    tick;
    check_val("rst_mid_q", q, 0);
    check_val("rst_mid_qbar", qb, 7);
    check_val("rst_mid_wrap", wrap, 0);
    check_val("rst_mid_lerr", lerr, 0);
    rst_b = 1'b1; load = 1'b1; d = 3'd7; en = 1'b0;
    tick;
    check_val("pre_rst_lerr", lerr, 1);
    rst_b = 1'b0;
    tick;
    check_val("rst_clr_lerr", lerr, 0);
    rst_b = 1'b1; load = 1'b1; d = 3'd5;
    tick;
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick;
    check_val("pre_rst_wrap", wrap, 1);
    rst_b = 1'b0;
    tick;
    check_val("rst_clr_wrap", wrap, 0);
    check_val("rst_clr_wrap_q", q, 0);
    rst_b = 1'b1; load = 1'b1; d = 3'd4; en = 1'b0;
    tick;
    load = 1'b0; rst_b = 1'b0;
    #3;
    check_val("rst_no_edge_q", q, 4);
    tick;
    check_val("rst_edge_q", q, 0);
    rst_b = 1'b1;

    // hold with En low while Up toggles
    load = 1'b1; d = 3'd2;
    tick;
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = i[0];
      check_val($sformatf("hold_tc[%0d]", i), tc, 0);
      tick;
      check_val($sformatf("hold_q[%0d]", i), q, 2);
      check_val($sformatf("hold_wrap[%0d]", i), wrap, 0);
    end

    // 16-state cascade through TC
    c_en = 1'b1; c_up = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check_val($sformatf("c_lo_tc[%0d]", k), lo_tc, (((k - 1) % 4) == 3) ? 1 : 0);
      tick;
      val = k % 16;
      e2 = 2'(val % 4); nb2 = ~e2;
      check_val($sformatf("c_lo_q[%0d]", k), lo_q, e2);
      check_val($sformatf("c_lo_qbar[%0d]", k), lo_qb, nb2);
      e2 = 2'(val / 4); nb2 = ~e2;
      check_val($sformatf("c_hi_q[%0d]", k), hi_q, e2);
      check_val($sformatf("c_hi_qbar[%0d]", k), hi_qb, nb2);
      check_val($sformatf("c_lo_wrap[%0d]", k), lo_wrap, ((val % 4) == 0) ? 1 : 0);
      check_val($sformatf("c_hi_wrap[%0d]", k), hi_wrap, (k == 16) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
